spi_slave_responder: RTL and testbench

//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) that lets an FPGA act as the target of an SPI master.

---
 rtl/spi_slave_responder.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target running in the io_clock domain: oversampled pins, rx/tx valid-ready streams.
// Back-to-back frames reload the reply shifter on the falling edge after each completed word.
module spi_slave_responder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 8'hFF
) (
  input  logic                  io_clock,
  input  logic                  io_reset,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_ss,
  input  logic                  io_spi_mosi,
  output logic                  io_spi_miso,
  output logic                  io_spi_misoEn,
  output logic                  io_rx_valid,
  input  logic                  io_rx_ready,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_overrun,
  output logic                  io_busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    ss_prev_q, ss_prev_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    reload_q, reload_d;
  logic [DATA_WIDTH-2:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    busy_q, busy_d;

  logic                    sclk_s, ss_s, mosi_s;
  logic                    sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                    word_done, rx_accept;
  logic [DATA_WIDTH-1:0]   rx_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign rx_word   = {rx_shift_q, mosi_s};
  assign rx_accept = rx_valid_q & io_rx_ready;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], io_spi_sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], io_spi_ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], io_spi_mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    reload_d    = reload_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = io_tx_valid ? io_tx_payload : IDLE_WORD;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = rx_word[DATA_WIDTH-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            reload_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // The fall after a completed word is the slot for fetching the next reply.
          if (reload_q) begin
            reload_d = 1'b0;
            state_d  = LOAD;
          end else if (bit_cnt_q != '0 && bit_cnt_q != FULL_CNT) begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      reload_d  = 1'b0;
    end

    // A word completing while the consumer takes the old one simply replaces it.
    if (word_done) begin
      if (!rx_valid_q || rx_accept) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_accept) begin
      rx_valid_d = 1'b0;
    end

    tx_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign io_spi_miso   = tx_shift_q[DATA_WIDTH-1] & busy_q;
  assign io_spi_misoEn = busy_q;
  assign io_busy       = busy_q;
  assign io_rx_valid   = rx_valid_q;
  assign io_rx_payload = rx_data_q;
  assign io_tx_ready   = tx_ready_q;
  assign io_overrun    = overrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-banged SPI master, a queue-fed reply source and an rx monitor.
// Expected bytes come from what the master sends and what the reply queue offers per frame.
module tb_spi_slave_responder;

  logic       io_clock;
  logic       io_reset;
  logic       io_spi_sclk;
  logic       io_spi_ss;
  logic       io_spi_mosi;
  logic       io_spi_miso;
  logic       io_spi_misoEn;
  logic       io_rx_valid;
  logic       io_rx_ready;
  logic [7:0] io_rx_payload;
  logic       io_tx_valid;
  logic       io_tx_ready;
  logic [7:0] io_tx_payload;
  logic       io_overrun;
  logic       io_busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         tx_hs = 0;
  int         overrun_cnt = 0;
  int         ready_viol = 0;
  logic       prev_ready = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_got[$];

  spi_slave_responder dut (
    .io_clock      (io_clock),
    .io_reset      (io_reset),
    .io_spi_sclk   (io_spi_sclk),
    .io_spi_ss     (io_spi_ss),
    .io_spi_mosi   (io_spi_mosi),
    .io_spi_miso   (io_spi_miso),
    .io_spi_misoEn (io_spi_misoEn),
    .io_rx_valid   (io_rx_valid),
    .io_rx_ready   (io_rx_ready),
    .io_rx_payload (io_rx_payload),
    .io_tx_valid   (io_tx_valid),
    .io_tx_ready   (io_tx_ready),
    .io_tx_payload (io_tx_payload),
    .io_overrun    (io_overrun),
    .io_busy       (io_busy)
  );

  initial begin
    io_clock = 1'b0;
    forever #5 io_clock = ~io_clock;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reply source: presents the queue head, pops it when a handshake happened.
  initial begin
    bit hs;
    io_tx_valid   = 1'b0;
    io_tx_payload = 8'h00;
    forever begin
      @(negedge io_clock);
      hs = io_tx_valid && io_tx_ready;
      @(posedge io_clock);
      #1;
      if (hs) begin
        void'(tx_q.pop_front());
        tx_hs++;
      end
      io_tx_valid   = (tx_q.size() > 0);
      io_tx_payload = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  // Monitor: records accepted rx words, overrun cycles and tx_ready protocol violations.
  initial begin
    forever begin
      @(negedge io_clock);
      if (io_rx_valid && io_rx_ready) rx_got.push_back(io_rx_payload);
      if (io_overrun) overrun_cnt++;
      if (io_tx_ready && (prev_ready || !io_busy)) ready_viol++;
      prev_ready = io_tx_ready;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge io_clock);
    #1;
  endtask

  // mode 1: check rx_valid latency after the last rise; mode 2: rx_ready high only in the completion cycle
  task automatic applyStimulus(input int nbits, input logic [7:0] mosi_byte, input int mode,
                               output logic [7:0] miso_byte);
    logic [7:0] shreg;
    miso_byte = 8'h00;
    shreg = mosi_byte;
    for (int i = 0; i < nbits; i++) begin
      io_spi_mosi = shreg[7];
      shreg = shreg << 1;
      waitCycles(8);
      miso_byte = {miso_byte[6:0], io_spi_miso};
      io_spi_sclk = 1'b1;
      if (i == nbits - 1 && mode == 1) begin
        repeat (2) @(posedge io_clock);
        @(negedge io_clock);
        checkOutput("rx_valid_before_latency", io_rx_valid, 1'b0);
        @(posedge io_clock);
        @(negedge io_clock);
        checkOutput("rx_valid_at_latency", io_rx_valid, 1'b1);
        waitCycles(5);
      end else if (i == nbits - 1 && mode == 2) begin
        waitCycles(2);
        io_rx_ready = 1'b1;
        waitCycles(1);
        io_rx_ready = 1'b0;
        waitCycles(5);
      end else begin
        waitCycles(8);
      end
      io_spi_sclk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] b;
    logic [7:0] w;
    logic [7:0] exp_b;
    logic [31:0] obs;
    int hs0;
    int ov0;
    int n0;
    bit have;

    io_reset    = 1'b1;
    io_spi_sclk = 1'b0;
    io_spi_ss   = 1'b1;
    io_spi_mosi = 1'b0;
    io_rx_ready = 1'b0;

    // Reset: all outputs low during and after reset, and sclk activity with ss high is ignored
    waitCycles(3);
    checkOutput("reset_outputs", {io_spi_miso, io_spi_misoEn, io_rx_valid, io_tx_ready, io_overrun, io_busy}, 6'b0);
    checkOutput("reset_rx_payload", io_rx_payload, 8'h00);
    io_reset = 1'b0;
    waitCycles(4);
    checkOutput("after_reset_outputs", {io_spi_miso, io_spi_misoEn, io_rx_valid, io_tx_ready, io_overrun, io_busy}, 6'b0);
    io_spi_mosi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_spi_sclk = 1'b1;
      waitCycles(8);
      io_spi_sclk = 1'b0;
      waitCycles(8);
    end
    checkOutput("ss_high_ignored", {io_spi_miso, io_spi_misoEn, io_rx_valid, io_busy}, 4'b0);

    // Single frame
    hs0 = tx_hs;
    tx_q.push_back(8'hA5);
    waitCycles(2);
    io_spi_ss = 1'b0;
    waitCycles(4);
    applyStimulus(8, 8'h3C, 1, got);
    waitCycles(4);
    io_spi_ss = 1'b1;
    waitCycles(6);
    checkOutput("single_miso", got, 8'hA5);
    checkOutput("single_rx_payload", io_rx_payload, 8'h3C);
    checkOutput("single_rx_valid", io_rx_valid, 1'b1);
    checkOutput("single_tx_handshakes", tx_hs - hs0, 1);
    io_rx_ready = 1'b1;
    waitCycles(3);
    checkOutput("single_drained", io_rx_valid, 1'b0);
    rx_got.delete();

    // Back-to-back: three frames in one ss assertion, only two reply words offered
    hs0 = tx_hs;
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    waitCycles(2);
    io_spi_ss = 1'b0;
    waitCycles(4);
    for (int k = 0; k < 3; k++) begin
      b = 8'(k + 1);
      exp_b = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'hFF;
      applyStimulus(8, b, 0, got);
      checkOutput($sformatf("b2b_miso_%0d", k), got, exp_b);
    end
    waitCycles(4);
    io_spi_ss = 1'b1;
    waitCycles(6);
    checkOutput("b2b_tx_handshakes", tx_hs - hs0, 2);
    for (int k = 0; k < 3; k++) begin
      obs = 32'hDEAD;
      if (rx_got.size() > 0) obs = 32'(rx_got.pop_front());
      checkOutput($sformatf("b2b_rx_%0d", k), obs, 32'(k + 1));
    end

    // Overrun: the consumer stalls, the second word is dropped
    io_rx_ready = 1'b0;
    ov0 = overrun_cnt;
    io_spi_ss = 1'b0;
    waitCycles(4);
    applyStimulus(8, 8'h55, 0, got);
    applyStimulus(8, 8'hAA, 0, got);
    waitCycles(4);
    io_spi_ss = 1'b1;
    waitCycles(6);
    checkOutput("overrun_payload_held", io_rx_payload, 8'h55);
    checkOutput("overrun_valid_held", io_rx_valid, 1'b1);
    checkOutput("overrun_pulses", overrun_cnt - ov0, 1);
    io_rx_ready = 1'b1;
    waitCycles(3);
    rx_got.delete();

    // Abort after 5 bits, then a full frame
    n0 = rx_got.size();
    io_spi_ss = 1'b0;
    waitCycles(4);
    applyStimulus(5, 8'hF0, 0, got);
    waitCycles(4);
    io_spi_ss = 1'b1;
    repeat (3) @(posedge io_clock);
    @(negedge io_clock);
    checkOutput("abort_misoEn_off", io_spi_misoEn, 1'b0);
    waitCycles(6);
    checkOutput("abort_no_rx", {io_rx_valid, 8'(rx_got.size() - n0)}, 9'h000);
    tx_q.push_back(8'h5A);
    waitCycles(2);
    io_spi_ss = 1'b0;
    waitCycles(4);
    applyStimulus(8, 8'h96, 0, got);
    waitCycles(4);
    io_spi_ss = 1'b1;
    waitCycles(6);
    checkOutput("abort_next_miso", got, 8'h5A);
    obs = 32'hDEAD;
    if (rx_got.size() > 0) obs = 32'(rx_got.pop_front());
    checkOutput("abort_next_rx", obs, 32'h96);

    // Same-cycle accept: rx_ready high only in the completion cycle of the second word
    io_rx_ready = 1'b0;
    ov0 = overrun_cnt;
    rx_got.delete();
    io_spi_ss = 1'b0;
    waitCycles(4);
    applyStimulus(8, 8'h12, 0, got);
    applyStimulus(8, 8'h34, 2, got);
    waitCycles(4);
    io_spi_ss = 1'b1;
    waitCycles(6);
    checkOutput("same_cycle_no_overrun", overrun_cnt - ov0, 0);
    checkOutput("same_cycle_payload", io_rx_payload, 8'h34);
    checkOutput("same_cycle_valid", io_rx_valid, 1'b1);
    obs = 32'hDEAD;
    if (rx_got.size() > 0) obs = 32'(rx_got.pop_front());
    checkOutput("same_cycle_first_taken", obs, 32'h12);
    io_rx_ready = 1'b1;
    waitCycles(3);
    rx_got.delete();

    // Random frames against the reference: reply = offered word or the idle word
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      w = 8'($urandom_range(0, 255));
      have = 1'($urandom_range(0, 1));
      if (have) tx_q.push_back(w);
      exp_b = have ? w : 8'hFF;
      waitCycles(2);
      io_spi_ss = 1'b0;
      waitCycles(4);
      applyStimulus(8, b, 0, got);
      waitCycles(4);
      io_spi_ss = 1'b1;
      waitCycles(6);
      checkOutput($sformatf("rand_miso_%0d", k), got, exp_b);
      obs = 32'hDEAD;
      if (rx_got.size() > 0) obs = 32'(rx_got.pop_front());
      checkOutput($sformatf("rand_rx_%0d", k), obs, 32'(b));
    end

    checkOutput("tx_ready_protocol", ready_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
